collision_probe_sched: RTL
==========================

Name: collision_probe_sched

Overview:
- Once per frame, sequences eight collision probes for the fireboy and watergirl characters.
- The probes are read through a dedicated, time-shared read port of the background map ROM (640x480, 3-bit palette index per pixel).
- A probe is a wall hit when its pixel index equals WALL_IDX.
- Results are presented atomically to the character motion logic after the last read returns.

Parameters:
- MAP_W, 640: map width in pixels; address stride.
- MAP_H, 480: map height in pixels.
- ROM_LAT, 1: ROM read latency in cycles (1..3).
- WALL_IDX, 3'd1: palette index that denotes solid wall.
- FIRE_SIDE_OFS, 15: rows above fire_bottom used for the fire left/right probes.
- FIRE_MID_OFS, 13: columns right of fire_left used for the fire top/bottom probes.
- WATER_SIDE_OFS, 25: same as FIRE_SIDE_OFS, for water.
- WATER_MID_OFS, 25: same as FIRE_MID_OFS, for water.

Ports:
- vga_clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse, once per frame.
- fire_left, fire_right, fire_top, fire_bottom  in  10 each  fire bounding box, pixels.
- water_left, water_right, water_top, water_bottom  in  10 each  water bounding box, pixels.
- rom_addr  out  19  registered probe address.
- rom_en  out  1  high while rom_addr carries a valid probe.
- rom_q  in  3  ROM data.
- fire_hit  out  4  {left,right,top,bottom} wall flags.
- water_hit  out  4  same ordering, for water.
- probe_done  out  1  one-cycle pulse when flags update.
- busy  out  1  sequence in progress.
- overrun  out  1  sticky; a frame_start arrived while busy.

Behaviour:
- Reset values (asserted asynchronously): state IDLE; rom_addr=0, rom_en=0, fire_hit=0, water_hit=0, probe_done=0, busy=0, overrun=0, shadow flags=0.
- States:
  - IDLE: waits for frame_start.
  - ISSUE: 8 cycles, probe index p=0..7.
  - DRAIN: ROM_LAT cycles.
  - DONE: 1 cycle, then returns to IDLE.
- Start: on the edge where IDLE samples frame_start=1:
  - all 16 coordinates are snapshotted;
  - state moves to ISSUE, p=0;
  - rom_en=1 and probe 0's address are registered.
- Cycle numbering: that following cycle is cycle 0; probe p's address is driven during cycle p.
- Probe order:
  - p0 fire L: x=fire_left, y=fire_bottom-FIRE_SIDE_OFS.
  - p1 fire R: x=fire_right, same y as p0.
  - p2 fire T: x=fire_left+FIRE_MID_OFS, y=fire_top.
  - p3 fire B: same x as p2, y=fire_bottom.
  - p4..p7: the same four probes for water, using the WATER_* offsets.
- Address arithmetic:
  - rom_addr = x + y*MAP_W, computed on 19 bits.
  - y is clamped to 0 on subtraction underflow and to MAP_H-1 above it.
  - x is clamped to MAP_W-1.
  - The multiply must not truncate before the add.
- Capture: rom_q belonging to probe p is sampled at the rising edge ending cycle p+ROM_LAT. Hit = (rom_q==WALL_IDX), written into shadow bit p.
- rom_en falls after cycle 7, and rom_addr holds its last value.
- DONE occupies cycle 8+ROM_LAT:
  - probe_done=1 for exactly that cycle;
  - shadow is copied to fire_hit/water_hit at the edge that starts DONE, all 8 bits together;
  - flags are never partially updated.
- Flags hold until the next DONE or reset.
- busy=1 during cycles 0 through 8+ROM_LAT inclusive.
- A frame_start arriving while not IDLE (including in DONE) is ignored and sets overrun=1; overrun clears only on reset.
- Coordinate changes after the snapshot do not affect the current sequence.
- Reset mid-sequence:
  - immediate abort;
  - flags return to 0, and no probe_done is produced;
  - the next frame_start after release starts a fresh sequence.
- rom_q is ignored outside the capture cycles.

Test Plan:
- Address check, reset then frame_start with fire_left=100, fire_right=120, fire_top=170, fire_bottom=200 → rom_addr for p0..p3 = 118500, 118520, 108913, 128113 in cycles 0..3, with rom_en=1 during cycles 0..7 only.
- ROM model, latency 1, returns WALL_IDX only for p1 and p6 → probe_done in cycle 9, fire_hit=4'b0100, water_hit=4'b0010, busy low from cycle 10.
- Clamping: water_left=5, water_bottom=10, water_right=700 → p4 addr=5 (y clamped 0), p5 addr=639, no X and no wrap.
- Overrun: second frame_start in cycle 4 → ignored, sequence completes normally, overrun=1 and sticky until reset_n low.
- Reset mid-sequence: reset_n low in cycle 5 → all outputs 0 asynchronously, no probe_done; a new frame_start gives a clean sequence.
- Latency parameter: ROM_LAT=3 with coordinates changed in cycle 2 → addresses use the snapshot values, probe_done in cycle 11, flags update atomically.

Source files
------------

// File: rtl/collision_probe_sched.sv
// Per-frame collision probe sequencer: issues eight wall probes for fireboy and watergirl
// through a shared map ROM port and publishes all hit flags together once the last read returns.
module collision_probe_sched #(
    parameter int         MAP_W          = 640,
    parameter int         MAP_H          = 480,
    parameter int         ROM_LAT        = 1,
    parameter logic [2:0] WALL_IDX       = 3'd1,
    parameter int         FIRE_SIDE_OFS  = 15,
    parameter int         FIRE_MID_OFS   = 13,
    parameter int         WATER_SIDE_OFS = 25,
    parameter int         WATER_MID_OFS  = 25
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [9:0]  fire_left,
    input  logic [9:0]  fire_right,
    input  logic [9:0]  fire_top,
    input  logic [9:0]  fire_bottom,
    input  logic [9:0]  water_left,
    input  logic [9:0]  water_right,
    input  logic [9:0]  water_top,
    input  logic [9:0]  water_bottom,
    output logic [18:0] rom_addr,
    output logic        rom_en,
    input  logic [2:0]  rom_q,
    output logic [3:0]  fire_hit,
    output logic [3:0]  water_hit,
    output logic        probe_done,
    output logic        busy,
    output logic        overrun
);

    localparam logic signed [11:0] X_MAX  = 12'(MAP_W - 1);
    localparam logic signed [11:0] Y_MAX  = 12'(MAP_H - 1);
    localparam logic signed [11:0] F_SIDE = 12'(FIRE_SIDE_OFS);
    localparam logic signed [11:0] F_MID  = 12'(FIRE_MID_OFS);
    localparam logic signed [11:0] W_SIDE = 12'(WATER_SIDE_OFS);
    localparam logic signed [11:0] W_MID  = 12'(WATER_MID_OFS);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [9:0]        live [8];
    logic [9:0]        snap [8];
    logic [9:0]        crd  [8];
    logic [2:0]        pidx;
    logic signed [11:0] px, py;
    logic [18:0]       addr_nxt;
    logic              vld_p [ROM_LAT];
    logic [2:0]        idx_p [ROM_LAT];
    logic [7:0]        shadow, shadow_nxt;

    function automatic logic signed [11:0] sx(input logic [9:0] v);
        return $signed({2'b00, v});
    endfunction

    function automatic logic [9:0] sat_x(input logic signed [11:0] x);
        if (x > X_MAX)
            return X_MAX[9:0];
        if (x < 12'sd0)
            return 10'd0;
        return x[9:0];
    endfunction

    function automatic logic [8:0] sat_y(input logic signed [11:0] y);
        if (y < 12'sd0)
            return 9'd0;
        if (y > Y_MAX)
            return Y_MAX[8:0];
        return y[8:0];
    endfunction

    // Both operands are widened to the full address width before the multiply.
    function automatic logic [18:0] probe_addr(input logic signed [11:0] x,
                                               input logic signed [11:0] y);
        logic [18:0] xs, ys;
        xs = {9'd0, sat_x(x)};
        ys = {10'd0, sat_y(y)};
        return xs + ys * 19'(MAP_W);
    endfunction

    function automatic logic is_wall(input logic [2:0] q);
        return q == WALL_IDX;
    endfunction

    assign live = '{fire_left, fire_right, fire_top, fire_bottom,
                    water_left, water_right, water_top, water_bottom};

    // Probe 0 is formed from the live inputs on the start edge; later probes from the snapshot.
    always_comb begin
        for (int i = 0; i < 8; i++)
            crd[i] = (state == IDLE) ? live[i] : snap[i];
        pidx = (state == IDLE) ? 3'd0 : cnt + 3'd1;
        px   = '0;
        py   = '0;
        case (pidx)
            3'd0: begin px = sx(crd[0]);          py = sx(crd[3]) - F_SIDE; end
            3'd1: begin px = sx(crd[1]);          py = sx(crd[3]) - F_SIDE; end
            3'd2: begin px = sx(crd[0]) + F_MID;  py = sx(crd[2]);          end
            3'd3: begin px = sx(crd[0]) + F_MID;  py = sx(crd[3]);          end
            3'd4: begin px = sx(crd[4]);          py = sx(crd[7]) - W_SIDE; end
            3'd5: begin px = sx(crd[5]);          py = sx(crd[7]) - W_SIDE; end
            3'd6: begin px = sx(crd[4]) + W_MID;  py = sx(crd[6]);          end
            3'd7: begin px = sx(crd[4]) + W_MID;  py = sx(crd[7]);          end
            default: begin px = '0; py = '0; end
        endcase
        addr_nxt = probe_addr(px, py);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = ISSUE;
                    cnt_nxt   = 3'd0;
                end
            end
            ISSUE: begin
                if (cnt == 3'd7) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            DRAIN: begin
                if (cnt == 3'(ROM_LAT - 1)) begin
                    state_nxt = DONE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The last capture and the flag publish share one edge, so publish from shadow_nxt.
    always_comb begin
        shadow_nxt = shadow;
        if (vld_p[ROM_LAT-1])
            shadow_nxt[idx_p[ROM_LAT-1]] = is_wall(rom_q);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            rom_addr   <= '0;
            rom_en     <= 1'b0;
            fire_hit   <= '0;
            water_hit  <= '0;
            probe_done <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            shadow     <= '0;
            for (int k = 0; k < ROM_LAT; k++)
                vld_p[k] <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shadow     <= shadow_nxt;
            busy       <= (state_nxt != IDLE);
            probe_done <= (state_nxt == DONE);
            if (frame_start && state != IDLE)
                overrun <= 1'b1;
            if ((state == IDLE && frame_start) || (state == ISSUE && cnt != 3'd7)) begin
                rom_en   <= 1'b1;
                rom_addr <= addr_nxt;
            end else begin
                rom_en <= 1'b0;
            end
            vld_p[0] <= (state == ISSUE);
            for (int k = 1; k < ROM_LAT; k++)
                vld_p[k] <= vld_p[k-1];
            if (state == DRAIN && state_nxt == DONE) begin
                fire_hit  <= {shadow_nxt[0], shadow_nxt[1], shadow_nxt[2], shadow_nxt[3]};
                water_hit <= {shadow_nxt[4], shadow_nxt[5], shadow_nxt[6], shadow_nxt[7]};
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (state == IDLE && frame_start)
            snap <= live;
        idx_p[0] <= cnt;
        for (int k = 1; k < ROM_LAT; k++)
            idx_p[k] <= idx_p[k-1];
    end

endmodule
